queue_ctrl: RTL and testbench

QUEUE_CTRL -- requirements
Module: queue_ctrl

---
 rtl/queue_pkg.sv | 14 +
 rtl/queue_ptr.sv | 21 ++
 rtl/queue_ctrl.sv | 142 ++++++++++++++
 tb/tb_queue_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// Shared types and default widths for the queue controller and its pointer sub-module.
package queue_pkg;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WSETUP  = 2'd1,
        WSTROBE = 2'd2,
        READ    = 2'd3
    } state_t;

endpackage

// File: rtl/queue_ptr.sv
// Wrapping RAM pointer; advances by one on inc and rolls over at 2**w naturally.
module queue_ptr
    import queue_pkg::*;
#(
    parameter int w = DEF_ADDR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [w-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/queue_ctrl.sv
// FIFO controller in front of a single-port async-read RAM; writes take a setup and a strobe cycle.
// Optional sticky misuse flag Err is built only when QUEUE_CTRL_ERR_EN is defined.
module queue_ctrl
    import queue_pkg::*;
#(
    parameter int bitPerWord  = DEF_WORD_W,
    parameter int bitOfColumn = DEF_ADDR_W
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   Push,
    input  logic [bitPerWord-1:0]  PushData,
    output logic                   PushReady,
    input  logic                   Pop,
    output logic                   PopReady,
    output logic [bitPerWord-1:0]  PopData,
    output logic                   PopValid,
    output logic                   Full,
    output logic                   Empty,
    output logic [bitOfColumn:0]   Count,
    output logic [bitOfColumn-1:0] RamAddr,
    output logic [bitPerWord-1:0]  RamDataIn,
    output logic                   RamRWS,
    output logic                   RamCS,
    input  logic [bitPerWord-1:0]  RamDataOut,
`ifdef QUEUE_CTRL_ERR_EN
    output logic                   Err,
`endif
    output state_t                 DbgState
);

    localparam logic [bitOfColumn:0] DEPTH = {1'b1, {bitOfColumn{1'b0}}};

    // Handshake: a request is taken on the rising edge where req & ready are both 1.
    state_t                 state, state_nxt;
    logic [bitPerWord-1:0]  wdata;
    logic [bitOfColumn-1:0] wptr, rptr;
    logic [bitOfColumn:0]   count;
    logic                   is_idle, push_acc, pop_acc, wr_done, rd_done;

    assign is_idle   = (state == IDLE);
    assign Full      = (count == DEPTH);
    assign Empty     = (count == '0);
    assign Count     = count;
    assign PopReady  = is_idle & ~Empty;
    assign pop_acc   = Pop & PopReady;
    assign PushReady = Reset_n & is_idle & ~Full & ~pop_acc;
    assign push_acc  = Push & PushReady;
    assign wr_done   = (state == WSTROBE);
    assign rd_done   = (state == READ);
    assign RamDataIn = wdata;
    assign DbgState  = state;

    queue_ptr #(.w(bitOfColumn)) u_wptr (
        .clk   (Clk),
        .rst_n (Reset_n),
        .inc   (wr_done),
        .ptr   (wptr)
    );

    queue_ptr #(.w(bitOfColumn)) u_rptr (
        .clk   (Clk),
        .rst_n (Reset_n),
        .inc   (rd_done),
        .ptr   (rptr)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // RAM strobes come straight from state so a reset drops them without waiting for a clock.
    always_comb begin
        state_nxt = state;
        RamCS     = 1'b0;
        RamRWS    = 1'b0;
        RamAddr   = '0;
        case (state)
            IDLE: begin
                if (pop_acc) begin
                    state_nxt = READ;
                end else if (push_acc) begin
                    state_nxt = WSETUP;
                end
            end
            WSETUP: begin
                RamCS     = 1'b1;
                RamAddr   = wptr;
                state_nxt = WSTROBE;
            end
            WSTROBE: begin
                RamCS     = 1'b1;
                RamRWS    = 1'b1;
                RamAddr   = wptr;
                state_nxt = IDLE;
            end
            READ: begin
                RamCS     = 1'b1;
                RamAddr   = rptr;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wdata    <= '0;
            count    <= '0;
            PopData  <= '0;
            PopValid <= 1'b0;
        end else begin
            if (push_acc) begin
                wdata <= PushData;
            end
            if (wr_done) begin
                count <= count + 1'b1;
            end else if (rd_done) begin
                count <= count - 1'b1;
            end
            if (rd_done) begin
                PopData <= RamDataOut;
            end
            PopValid <= rd_done;
        end
    end

`ifdef QUEUE_CTRL_ERR_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Err <= 1'b0;
        end else if ((Push & Full) | (Pop & Empty)) begin
            Err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_queue_ctrl.sv
// Scoreboard bench for queue_ctrl with a behavioural async-read RAM attached.
module tb_queue_ctrl;
    import queue_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Push = 1'b0;
    logic [7:0] PushData = '0;
    logic       PushReady;
    logic       Pop = 1'b0;
    logic       PopReady;
    logic [7:0] PopData;
    logic       PopValid;
    logic       Full, Empty;
    logic [5:0] Count;
    logic [4:0] RamAddr;
    logic [7:0] RamDataIn;
    logic       RamRWS, RamCS;
    logic [7:0] RamDataOut;
    state_t     DbgState;
`ifdef QUEUE_CTRL_ERR_EN
    logic       Err;
`endif

    queue_ctrl #(.bitPerWord(8), .bitOfColumn(5)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Push       (Push),
        .PushData   (PushData),
        .PushReady  (PushReady),
        .Pop        (Pop),
        .PopReady   (PopReady),
        .PopData    (PopData),
        .PopValid   (PopValid),
        .Full       (Full),
        .Empty      (Empty),
        .Count      (Count),
        .RamAddr    (RamAddr),
        .RamDataIn  (RamDataIn),
        .RamRWS     (RamRWS),
        .RamCS      (RamCS),
        .RamDataOut (RamDataOut),
`ifdef QUEUE_CTRL_ERR_EN
        .Err        (Err),
`endif
        .DbgState   (DbgState)
    );

    always #5 Clk = ~Clk;

    logic [7:0] mem [32];
    assign RamDataOut = mem[RamAddr];
    always @(posedge Clk) begin
        if (RamCS && RamRWS) mem[RamAddr] <= RamDataIn;
    end

    int checks = 0;
    int errors = 0;
    logic [7:0]  exp_q[$];
    logic [12:0] exp_wr_q[$];
    logic [4:0]  m_wptr = '0;
    int          m_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: RAM bus protocol, write contents and pop data against the expected queues.
    int         cs_run = 0;
    logic       wr_seen = 1'b0, prev_rws = 1'b0, prev_valid = 1'b0;
    logic [4:0] prev_addr = '0;
    logic [7:0] prev_din = '0;
    always @(negedge Clk) begin
        if (!Reset_n) begin
            cs_run = 0;
            wr_seen = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (RamRWS && !RamCS) check("rws_without_cs", 32'(RamRWS), 32'd0);
            if (RamCS) begin
                if (RamRWS) begin
                    check("wstrobe_after_setup", 32'((cs_run == 1) && !prev_rws), 32'd1);
                    check("wstrobe_hold", 32'({RamAddr, RamDataIn} == {prev_addr, prev_din}), 32'd1);
                    if (exp_wr_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
                    else check("ram_write", 32'({RamAddr, RamDataIn}), 32'(exp_wr_q.pop_front()));
                    wr_seen = 1'b1;
                end
                cs_run++;
                prev_addr = RamAddr;
                prev_din  = RamDataIn;
                prev_rws  = RamRWS;
            end else if (cs_run != 0) begin
                check("cs_width", 32'(cs_run), wr_seen ? 32'd2 : 32'd1);
                cs_run = 0;
                wr_seen = 1'b0;
            end
            if (PopValid) begin
                if (prev_valid) check("popvalid_width", 32'd2, 32'd1);
                if (exp_q.size() == 0) check("unexpected_pop", 32'd1, 32'd0);
                else check("pop_data", 32'(PopData), 32'(exp_q.pop_front()));
            end
            prev_valid = PopValid;
        end
    end

    task automatic do_push(input logic [7:0] d);
        int n = 0;
        @(negedge Clk);
        Push = 1'b1;
        PushData = d;
        #1;
        while (!PushReady && n < 40) begin
            @(negedge Clk);
            #1;
            n++;
        end
        if (PushReady) begin
            exp_wr_q.push_back({m_wptr, d});
            exp_q.push_back(d);
            m_wptr++;
            m_count++;
        end else begin
            check("push_timeout", 32'd0, 32'd1);
        end
        @(negedge Clk);
        Push = 1'b0;
    endtask

    task automatic do_pop();
        int n = 0;
        @(negedge Clk);
        Pop = 1'b1;
        #1;
        while (!PopReady && n < 40) begin
            @(negedge Clk);
            #1;
            n++;
        end
        if (PopReady) m_count--;
        else check("pop_timeout", 32'd0, 32'd1);
        @(negedge Clk);
        Pop = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge Clk);
        while (DbgState != IDLE && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (DbgState != IDLE) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_level(input string tag);
        check({tag, "_count"}, 32'(Count), 32'(m_count));
        check({tag, "_empty"}, 32'(Empty), 32'(m_count == 0));
        check({tag, "_full"}, 32'(Full), 32'(m_count == 32));
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) mem[i] = '0;

        // Reset values while Reset_n is held low
        repeat (3) @(negedge Clk);
        check("rst_count", 32'(Count), 32'd0);
        check("rst_empty", 32'(Empty), 32'd1);
        check("rst_full", 32'(Full), 32'd0);
        check("rst_push_ready", 32'(PushReady), 32'd0);
        check("rst_pop_ready", 32'(PopReady), 32'd0);
        check("rst_pop_valid", 32'(PopValid), 32'd0);
        check("rst_pop_data", 32'(PopData), 32'd0);
        check("rst_ram_cs", 32'(RamCS), 32'd0);
        check("rst_ram_rws", 32'(RamRWS), 32'd0);
        check("rst_ram_addr", 32'(RamAddr), 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);
        check("idle_push_ready", 32'(PushReady), 32'd1);

        // Three pushes land at addresses 0, 1, 2; then three pops return them in order
        do_push(8'd7);
        do_push(8'd30);
        do_push(8'd14);
        wait_idle();
        check_level("three_pushed");
        for (int i = 0; i < 3; i++) do_pop();
        wait_idle();
        @(negedge Clk);
        check_level("three_popped");
        check("three_popped_drained", 32'(exp_q.size()), 32'd0);

        // Fill all 32 entries, then a 33rd push is refused
        for (int i = 0; i < 32; i++) do_push(8'(i));
        wait_idle();
        check_level("filled");
        check("filled_push_ready", 32'(PushReady), 32'd0);
        @(negedge Clk);
        Push = 1'b1;
        PushData = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            #1 check("push_when_full_ready", 32'(PushReady), 32'd0);
            @(negedge Clk);
        end
        Push = 1'b0;
        check_level("after_overflow");
`ifdef QUEUE_CTRL_ERR_EN
        check("err_on_overflow", 32'(Err), 32'd1);
`endif
        for (int i = 0; i < 32; i++) do_pop();
        wait_idle();
        @(negedge Clk);
        check_level("full_drained");

        // Simultaneous push and pop with one word stored: pop goes first
        do_push(8'd55);
        wait_idle();
        @(negedge Clk);
        Push = 1'b1;
        Pop = 1'b1;
        PushData = 8'd66;
        #1;
        check("both_pop_ready", 32'(PopReady), 32'd1);
        check("both_push_ready", 32'(PushReady), 32'd0);
        m_count--;
        @(negedge Clk);
        Pop = 1'b0;
        check("both_state_read", 32'(DbgState), 32'(READ));
        do_push(8'd66);
        wait_idle();
        check_level("both_done");
        do_pop();
        wait_idle();
        @(negedge Clk);
        check_level("both_drained");

        // Interleaved traffic long enough to wrap both pointers past 31
        for (int i = 0; i < 36; i++) begin
            do_push(8'(i * 7 + 3));
            do_pop();
        end
        wait_idle();
        @(negedge Clk);
        check_level("wrap_done");

        // Reset during the write strobe aborts immediately
        do_push(8'h5A);
        n = 0;
        while (DbgState != WSTROBE && n < 10) begin
            @(negedge Clk);
            n++;
        end
        check("reached_wstrobe", 32'(DbgState), 32'(WSTROBE));
        #1 Reset_n = 1'b0;
        #1;
        check("abort_ram_cs", 32'(RamCS), 32'd0);
        check("abort_ram_rws", 32'(RamRWS), 32'd0);
        check("abort_count", 32'(Count), 32'd0);
        check("abort_empty", 32'(Empty), 32'd1);
        exp_q.delete();
        exp_wr_q.delete();
        m_count = 0;
        m_wptr = '0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
`ifdef QUEUE_CTRL_ERR_EN
        check("err_cleared_by_reset", 32'(Err), 32'd0);
`endif

        // Pop while empty is ignored
        @(negedge Clk);
        Pop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("pop_when_empty_ready", 32'(PopReady), 32'd0);
            @(negedge Clk);
        end
        Pop = 1'b0;
        repeat (2) @(negedge Clk);
        check_level("after_underflow");
`ifdef QUEUE_CTRL_ERR_EN
        check("err_on_underflow", 32'(Err), 32'd1);
`endif

        // Pointers restart at address 0 after reset
        do_push(8'h11);
        do_pop();
        wait_idle();

        n = 0;
        while ((exp_q.size() != 0 || exp_wr_q.size() != 0) && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check("final_pop_queue", 32'(exp_q.size()), 32'd0);
        check("final_write_queue", 32'(exp_wr_q.size()), 32'd0);
        check_level("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
